// File: rtl/pi_spi_master_if.sv
// rtl/pi_spi_master_if.sv - frame stream and SPI pin bundle for pi_spi_master
interface pi_spi_master_if #(
  parameter int WIDTH = 48
);
  logic [WIDTH-1:0] tx_tdata;
  logic             tx_tuser;
  logic             tx_tvalid;
  logic             tx_tready;
  logic [WIDTH-1:0] rx_tdata;
  logic             rx_tvalid;
  logic             spi_sck;
  logic             spi_mosi;
  logic             spi_miso;
  logic [1:0]       spi_ce;

  modport master (
    input  tx_tdata, tx_tuser, tx_tvalid, spi_miso,
    output tx_tready, rx_tdata, rx_tvalid, spi_sck, spi_mosi, spi_ce
  );

  modport slave (
    output tx_tdata, tx_tuser, tx_tvalid, spi_miso,
    input  tx_tready, rx_tdata, rx_tvalid, spi_sck, spi_mosi, spi_ce
  );
endinterface

// File: rtl/pi_spi_master.sv
// rtl/pi_spi_master.sv - mode-0 SPI master moving one WIDTH-bit frame per handshake
module pi_spi_master #(
  parameter int WIDTH  = 48,
  parameter int CLKDIV = 4
) (
  input  logic            clk,
  input  logic            rst,
  pi_spi_master_if.master bus
);
  localparam int              BW       = $clog2(WIDTH);
  localparam logic [7:0]      H_LAST   = 8'(CLKDIV - 1);
  localparam logic [7:0]      GAP_LAST = 8'((CLKDIV > 1) ? CLKDIV - 2 : 0);
  localparam logic [BW-1:0]   BIT_TOP  = BW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

  state_t           state;
  logic [7:0]       div_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-2:0] tx_sh;
  logic [WIDTH-1:0] rx_sh;
  logic             finish;

  // GAP runs one cycle short: the returning IDLE cycle is the last deselected
  // cycle, so chip enables stay high for H cycles between back-to-back frames.
  assign finish = ((state == HOLD) && (div_cnt == H_LAST) && (CLKDIV == 1)) ||
                  ((state == GAP)  && (div_cnt == GAP_LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      div_cnt       <= '0;
      bit_cnt       <= '0;
      tx_sh         <= '0;
      rx_sh         <= '0;
      bus.tx_tready <= 1'b1;
      bus.rx_tvalid <= 1'b0;
      bus.rx_tdata  <= '0;
      bus.spi_sck   <= 1'b0;
      bus.spi_mosi  <= 1'b0;
      bus.spi_ce    <= 2'b11;
    end else begin
      bus.rx_tvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.tx_tvalid) begin
            tx_sh         <= bus.tx_tdata[WIDTH-2:0];
            bus.spi_mosi  <= bus.tx_tdata[WIDTH-1];
            bus.spi_ce    <= bus.tx_tuser ? 2'b01 : 2'b10;
            bus.tx_tready <= 1'b0;
            div_cnt       <= '0;
            state         <= SETUP;
          end
        end
        SETUP: begin
          if (div_cnt == H_LAST) begin
            div_cnt     <= '0;
            bit_cnt     <= BIT_TOP;
            bus.spi_sck <= 1'b1;
            rx_sh       <= {rx_sh[WIDTH-2:0], bus.spi_miso};
            state       <= XFER;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        XFER: begin
          if (div_cnt != H_LAST) begin
            div_cnt <= div_cnt + 8'd1;
          end else begin
            div_cnt <= '0;
            if (bus.spi_sck) begin
              bus.spi_sck <= 1'b0;
              if (bit_cnt != '0) begin
                bus.spi_mosi <= tx_sh[WIDTH-2];
                tx_sh        <= {tx_sh[WIDTH-3:0], 1'b0};
              end
            end else if (bit_cnt == '0) begin
              state <= HOLD;
            end else begin
              bit_cnt     <= bit_cnt - BW'(1);
              bus.spi_sck <= 1'b1;
              rx_sh       <= {rx_sh[WIDTH-2:0], bus.spi_miso};
            end
          end
        end
        HOLD: begin
          if (div_cnt == H_LAST) begin
            div_cnt    <= '0;
            bus.spi_ce <= 2'b11;
            state      <= GAP;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        GAP: begin
          if (div_cnt == GAP_LAST) begin
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase

      if (finish) begin
        state         <= IDLE;
        bus.tx_tready <= 1'b1;
        bus.rx_tvalid <= 1'b1;
        bus.rx_tdata  <= rx_sh;
      end
    end
  end
endmodule

// File: tb/tb_pi_spi_master.sv
// tb/tb_pi_spi_master.sv - three-configuration bench for pi_spi_master with a frame-timing model
module tb_pi_spi_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pi_spi_master_if #(.WIDTH(48)) b0 ();
  pi_spi_master_if #(.WIDTH(48)) b1 ();
  pi_spi_master_if #(.WIDTH(8))  b2 ();

  pi_spi_master #(.WIDTH(48), .CLKDIV(2)) u_h2 (.clk(clk), .rst(rst), .bus(b0));
  pi_spi_master #(.WIDTH(48), .CLKDIV(4)) u_h4 (.clk(clk), .rst(rst), .bus(b1));
  pi_spi_master #(.WIDTH(8),  .CLKDIV(1)) u_h1 (.clk(clk), .rst(rst), .bus(b2));

  logic [63:0] td [3];
  logic        tu [3];
  logic        tv [3];
  logic [63:0] rs [3];
  logic        miso [3];

  logic [63:0] o_rx [3];
  logic        o_rxv [3], o_rdy [3], o_sck [3], o_mosi [3];
  logic [1:0]  o_ce [3];

  assign b0.tx_tdata = td[0][47:0]; assign b0.tx_tuser = tu[0]; assign b0.tx_tvalid = tv[0]; assign b0.spi_miso = miso[0];
  assign b1.tx_tdata = td[1][47:0]; assign b1.tx_tuser = tu[1]; assign b1.tx_tvalid = tv[1]; assign b1.spi_miso = miso[1];
  assign b2.tx_tdata = td[2][7:0];  assign b2.tx_tuser = tu[2]; assign b2.tx_tvalid = tv[2]; assign b2.spi_miso = miso[2];

  assign o_rx[0] = {16'd0, b0.rx_tdata}; assign o_rxv[0] = b0.rx_tvalid; assign o_rdy[0] = b0.tx_tready;
  assign o_sck[0] = b0.spi_sck; assign o_mosi[0] = b0.spi_mosi; assign o_ce[0] = b0.spi_ce;
  assign o_rx[1] = {16'd0, b1.rx_tdata}; assign o_rxv[1] = b1.rx_tvalid; assign o_rdy[1] = b1.tx_tready;
  assign o_sck[1] = b1.spi_sck; assign o_mosi[1] = b1.spi_mosi; assign o_ce[1] = b1.spi_ce;
  assign o_rx[2] = {56'd0, b2.rx_tdata}; assign o_rxv[2] = b2.rx_tvalid; assign o_rdy[2] = b2.tx_tready;
  assign o_sck[2] = b2.spi_sck; assign o_mosi[2] = b2.spi_mosi; assign o_ce[2] = b2.spi_ce;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic known = 1'b0;

  // frame model state and observation counters, one slot per DUT
  logic        act [3]      = '{1'b0, 1'b0, 1'b0};
  int          k [3]        = '{0, 0, 0};
  logic [63:0] md [3]       = '{64'd0, 64'd0, 64'd0};
  logic        mu [3]       = '{1'b0, 1'b0, 1'b0};
  logic [63:0] mr [3]       = '{64'd0, 64'd0, 64'd0};
  logic [63:0] exp_rx [3]   = '{64'd0, 64'd0, 64'd0};
  logic [63:0] mosi_cap [3] = '{64'd0, 64'd0, 64'd0};
  logic        prev_sck [3] = '{1'b0, 1'b0, 1'b0};
  int acc_cnt [3]  = '{0, 0, 0};
  int acc_cyc [3]  = '{0, 0, 0};
  int rxv_cnt [3]  = '{0, 0, 0};
  int rxv_cyc [3]  = '{0, 0, 0};
  int rise_cnt [3] = '{0, 0, 0};
  int ce0_low [3]  = '{0, 0, 0};
  int ce1_low [3]  = '{0, 0, 0};
  int gap_run [3]  = '{0, 0, 0};
  int last_gap [3] = '{0, 0, 0};
  int slv_idx [3]  = '{0, 0, 0};

  typedef struct packed {
    logic [1:0] ce;
    logic       sck;
    logic       mosi;
    logic       mosi_chk;
    logic       tready;
    logic       rxv;
  } exp_t;

  exp_t e;

  function automatic int hof(input int i);
    case (i)
      0:       return 2;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  function automatic int wof(input int i);
    return (i == 2) ? 8 : 48;
  endfunction

  // Pin values k cycles after the accepting cycle, from the frame timeline:
  // H setup, W bits of (H high + H low), H hold, H-1 gap, then the rx_tvalid cycle.
  function automatic exp_t model_at(input logic a, input int kk, input int h, input int w,
                                    input logic [63:0] d, input logic u);
    exp_t r;
    int t, j;
    logic [1:0] sel;
    sel = u ? 2'b01 : 2'b10;
    r.ce = 2'b11; r.sck = 1'b0; r.mosi = 1'b0; r.mosi_chk = 1'b0; r.tready = !a; r.rxv = 1'b0;
    if (a) begin
      if (kk <= h) begin
        r.ce = sel; r.mosi = d[w-1]; r.mosi_chk = 1'b1;
      end else if (kk <= h + 2*h*w) begin
        t = kk - h - 1;
        j = t / (2*h);
        r.ce = sel;
        r.sck = ((t % (2*h)) < h);
        r.mosi_chk = 1'b1;
        if (r.sck || j == w - 1) r.mosi = d[w-1-j];
        else r.mosi = d[w-2-j];
      end else if (kk <= h*(2*w+2)) begin
        r.ce = sel;
      end else if (kk == h*(2*w+3)) begin
        r.tready = 1'b1; r.rxv = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input int i, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %h, expected %h", name, i, cyc, got, want);
    end
  endtask

  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      e = model_at(act[i], k[i], hof(i), wof(i), md[i], mu[i]);
      if (e.rxv) exp_rx[i] = mr[i];
      if (known) begin
        chk("spi_ce", i, 64'(o_ce[i]), 64'(e.ce));
        chk("spi_sck", i, 64'(o_sck[i]), 64'(e.sck));
        if (e.mosi_chk) chk("spi_mosi", i, 64'(o_mosi[i]), 64'(e.mosi));
        chk("tx_tready", i, 64'(o_rdy[i]), 64'(e.tready));
        chk("rx_tvalid", i, 64'(o_rxv[i]), 64'(e.rxv));
        chk("rx_tdata", i, o_rx[i], exp_rx[i]);
      end
      if (o_sck[i] === 1'b1 && prev_sck[i] === 1'b0) begin
        rise_cnt[i]++;
        mosi_cap[i] = {mosi_cap[i][62:0], o_mosi[i]};
      end
      if (o_sck[i] === 1'b0 && prev_sck[i] === 1'b1) slv_idx[i]++;
      prev_sck[i] = o_sck[i];
      if (o_ce[i] === 2'b11) begin
        slv_idx[i] = 0;
        gap_run[i]++;
      end else begin
        if (gap_run[i] > 0) last_gap[i] = gap_run[i];
        gap_run[i] = 0;
      end
      if (o_ce[i][0] === 1'b0) ce0_low[i]++;
      if (o_ce[i][1] === 1'b0) ce1_low[i]++;
      if (o_rxv[i] === 1'b1) begin
        rxv_cnt[i]++;
        rxv_cyc[i] = cyc;
      end
      if (rst) begin
        act[i] = 1'b0; k[i] = 0; exp_rx[i] = 64'd0;
      end else if ((!act[i] || e.rxv) && tv[i]) begin
        act[i] = 1'b1; k[i] = 1; md[i] = td[i]; mu[i] = tu[i]; mr[i] = rs[i];
        acc_cnt[i]++; acc_cyc[i] = cyc;
      end else if (act[i]) begin
        if (e.rxv) act[i] = 1'b0;
        else k[i]++;
      end
      miso[i] = (slv_idx[i] < wof(i)) ? mr[i][wof(i)-1-slv_idx[i]] : 1'b0;
    end
    if (rst) known = 1'b1;
  end

  task automatic start_frame(input int i, input logic [63:0] d, input logic u, input logic [63:0] r);
    int n;
    @(posedge clk); #1;
    td[i] = d; tu[i] = u; rs[i] = r; tv[i] = 1'b1;
    n = acc_cnt[i];
    for (int t = 0; t < 100 && acc_cnt[i] == n; t++) @(posedge clk);
    #1 tv[i] = 1'b0;
    chk("accept", i, 64'(acc_cnt[i] - n), 64'd1);
  endtask

  task automatic wait_idle(input int i);
    for (int t = 0; t < 3000 && act[i]; t++) @(negedge clk);
    #1 chk("frame_done", i, 64'(act[i]), 64'd0);
  endtask

  initial begin
    int n, a_cyc, b_rise, b_c0, b_c1, b_rxv;
    for (int i = 0; i < 3; i++) begin
      td[i] = 64'd0; tu[i] = 1'b0; tv[i] = 1'b0; rs[i] = 64'd0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_tready", i, 64'(o_rdy[i]), 64'd1);
      chk("reset_ce", i, 64'(o_ce[i]), 64'd3);
      chk("reset_sck", i, 64'(o_sck[i]), 64'd0);
      chk("reset_mosi", i, 64'(o_mosi[i]), 64'd0);
      chk("reset_rxv", i, 64'(o_rxv[i]), 64'd0);
      chk("reset_rx", i, o_rx[i], 64'd0);
    end

    // 48-bit frame at H=2 on chip enable 0
    b_rise = rise_cnt[0]; b_c0 = ce0_low[0]; b_c1 = ce1_low[0];
    start_frame(0, 64'h0500_0000_0123, 1'b0, 64'h0000_0000_4903);
    wait_idle(0);
    chk("h2_rx", 0, o_rx[0], 64'h0000_0000_4903);
    chk("h2_latency", 0, 64'(rxv_cyc[0] - acc_cyc[0]), 64'd198);
    chk("h2_mosi_bits", 0, mosi_cap[0] & 64'hFFFF_FFFF_FFFF, 64'h0500_0000_0123);
    chk("h2_sck_rises", 0, 64'(rise_cnt[0] - b_rise), 64'd48);
    chk("h2_ce1_low", 0, 64'(ce1_low[0] - b_c1), 64'd0);
    chk("h2_ce0_low", 0, 64'(ce0_low[0] - b_c0), 64'd196);

    // 8-bit frame at H=1
    b_rise = rise_cnt[2];
    start_frame(2, 64'hA5, 1'b0, 64'h3C);
    wait_idle(2);
    chk("h1_rx", 2, o_rx[2], 64'h3C);
    chk("h1_latency", 2, 64'(rxv_cyc[2] - acc_cyc[2]), 64'd19);
    chk("h1_mosi_bits", 2, mosi_cap[2] & 64'hFF, 64'hA5);
    chk("h1_sck_rises", 2, 64'(rise_cnt[2] - b_rise), 64'd8);

    // all-ones frame at H=4 on chip enable 1
    b_rise = rise_cnt[1]; b_c0 = ce0_low[1]; b_c1 = ce1_low[1];
    start_frame(1, 64'hFFFF_FFFF_FFFF, 1'b1, 64'h8000_0000_0001);
    wait_idle(1);
    chk("ce1_rx", 1, o_rx[1], 64'h8000_0000_0001);
    chk("ce1_sck_rises", 1, 64'(rise_cnt[1] - b_rise), 64'd48);
    chk("ce1_ce0_low", 1, 64'(ce0_low[1] - b_c0), 64'd0);
    chk("ce1_ce1_low", 1, 64'(ce1_low[1] - b_c1), 64'd392);

    // back-to-back frames with tx_tvalid held high
    @(posedge clk); #1;
    td[1] = 64'h1234_5678_9ABC; rs[1] = 64'hCAFE_0000_BEEF; tu[1] = 1'b0; tv[1] = 1'b1;
    n = acc_cnt[1];
    for (int t = 0; t < 100 && acc_cnt[1] == n; t++) @(posedge clk);
    #1 td[1] = 64'hA5A5_5A5A_0F0F; rs[1] = 64'h0123_4567_89AB;
    a_cyc = acc_cyc[1];
    n = acc_cnt[1];
    for (int t = 0; t < 1000 && acc_cnt[1] == n; t++) @(posedge clk);
    #1 tv[1] = 1'b0;
    chk("b2b_second_accept", 1, 64'(acc_cnt[1] - n), 64'd1);
    chk("b2b_accept_in_rxv", 1, 64'(acc_cyc[1]), 64'(rxv_cyc[1]));
    chk("b2b_first_latency", 1, 64'(rxv_cyc[1] - a_cyc), 64'd396);
    wait_idle(1);
    chk("b2b_gap", 1, 64'(last_gap[1]), 64'd4);
    chk("b2b_rx", 1, o_rx[1], 64'h0123_4567_89AB);

    // reset after 10 sck rising edges aborts the frame
    b_rise = rise_cnt[1]; b_rxv = rxv_cnt[1];
    start_frame(1, 64'hDEAD_BEEF_0001, 1'b0, 64'h1111_2222_3333);
    for (int t = 0; t < 1000 && (rise_cnt[1] - b_rise) < 10; t++) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("abort_ce", 1, 64'(o_ce[1]), 64'd3);
    chk("abort_sck", 1, 64'(o_sck[1]), 64'd0);
    chk("abort_tready", 1, 64'(o_rdy[1]), 64'd1);
    chk("abort_rx", 1, o_rx[1], 64'd0);
    repeat (450) @(negedge clk);
    chk("abort_no_rxv", 1, 64'(rxv_cnt[1] - b_rxv), 64'd0);
    start_frame(1, 64'h0F0F_F0F0_1234, 1'b0, 64'h5555_AAAA_C3C3);
    wait_idle(1);
    chk("post_abort_rx", 1, o_rx[1], 64'h5555_AAAA_C3C3);
    chk("post_abort_mosi", 1, mosi_cap[1] & 64'hFFFF_FFFF_FFFF, 64'h0F0F_F0F0_1234);

    // tx_tvalid pulse in mid-frame is ignored
    b_rxv = rxv_cnt[0]; n = acc_cnt[0];
    start_frame(0, 64'h8000_0000_0001, 1'b1, 64'h7FFF_FFFF_FFFE);
    repeat (30) @(posedge clk);
    #1 td[0] = 64'h1234_1234_1234; rs[0] = 64'd0; tv[0] = 1'b1;
    @(posedge clk); #1 tv[0] = 1'b0;
    wait_idle(0);
    repeat (20) @(negedge clk);
    chk("midpulse_accepts", 0, 64'(acc_cnt[0] - n), 64'd1);
    chk("midpulse_rxv", 0, 64'(rxv_cnt[0] - b_rxv), 64'd1);
    chk("midpulse_rx", 0, o_rx[0], 64'h7FFF_FFFF_FFFE);
    chk("midpulse_mosi", 0, mosi_cap[0] & 64'hFFFF_FFFF_FFFF, 64'h8000_0000_0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish within 100000 cycles");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/pi_spi_master.md
PI_SPI_MASTER -- requirements
Module: pi_spi_master

Interface
REQ-001 SHALL have parameter WIDTH, default 48, frame length in bits; legal 8..64.
REQ-002 SHALL have parameter CLKDIV, default 4, SCK half-period H in clk cycles; legal 1..255.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port tx_tdata  input  WIDTH  frame to send, MSB first.
REQ-006 SHALL have port tx_tuser  input  1  chip-select index: 0 selects spi_ce[0], 1 selects spi_ce[1].
REQ-007 SHALL have port tx_tvalid  input  1  frame offered.
REQ-008 SHALL have port tx_tready  output  1  block idle, frame acceptable.
REQ-009 SHALL have port rx_tdata  output  WIDTH  frame captured from spi_miso, MSB first.
REQ-010 SHALL have port rx_tvalid  output  1  one-cycle pulse, rx_tdata valid.
REQ-011 SHALL have port spi_sck  output  1  serial clock, mode 0, idle low.
REQ-012 SHALL have port spi_mosi  output  1  serial data out.
REQ-013 SHALL have port spi_miso  input  1  serial data in.
REQ-014 SHALL have port spi_ce  output  2  active-low chip enables.

Function
REQ-015 SHALL implement states IDLE, SETUP, XFER, HOLD, GAP; only IDLE asserts tx_tready.
REQ-016 SHALL accept a frame on the cycle tx_tvalid and tx_tready are both high (T0): latch tx_tdata and tx_tuser, enter SETUP.
REQ-017 SHALL, in SETUP: drive the selected spi_ce bit low, the other high, spi_mosi = bit WIDTH-1, spi_sck low, for H cycles.
REQ-018 SHALL, in XFER, per bit: spi_sck high H cycles, then low H cycles; WIDTH bits total (2*H*WIDTH cycles).
REQ-019 SHALL shift spi_miso into the capture register on each sck low-to-high transition.
REQ-020 SHALL update spi_mosi to the next bit on each sck high-to-low transition except the last; spi_mosi stable whenever sck is high.
REQ-021 SHALL use a bit counter counting WIDTH-1 down to 0; XFER exits after the falling edge of bit 0, with no wrap or extra bit.
REQ-022 SHALL, in HOLD: keep spi_ce asserted and spi_sck low for H cycles.
REQ-023 SHALL, in GAP: spi_ce = 2'b11 for H cycles.
REQ-024 SHALL pulse rx_tvalid for exactly one cycle at T0 + H*(2*WIDTH+3), re-entering IDLE with tx_tready high in that same cycle.
REQ-025 SHALL hold rx_tdata stable from the rx_tvalid pulse until the next rx_tvalid pulse.
REQ-026 SHALL ignore tx_tvalid while tx_tready is low; no queuing.
REQ-027 SHALL, if tx_tvalid is held high, accept the next frame in the rx_tvalid cycle; ce deasserted for at least H cycles between frames.
REQ-028 SHALL never assert both spi_ce bits low simultaneously.
REQ-029 SHALL, when CLKDIV=1, produce spi_sck at clk/2 with identical sequencing.

Reset
REQ-030 SHALL, on rst high, at the next clk edge set: state IDLE, spi_ce=2'b11, spi_sck=0, spi_mosi=0, tx_tready=1, rx_tvalid=0, rx_tdata=0, counters=0.
REQ-031 SHALL abort any frame in progress on rst, with no rx_tvalid for the aborted frame.
REQ-032 SHALL ignore tx_tvalid in any cycle rst is high.

Verification
REQ-033 SHALL pass this case: WIDTH=48, CLKDIV=2, tx_tdata=48'h0500_0000_0123, tx_tuser=0; slave model returns 48'h0000_0000_4903 -> MOSI bits match, rx_tdata=48'h0000_0000_4903, rx_tvalid at T0+198, spi_ce[1] high throughout.
REQ-034 SHALL pass this case: tx_tuser=1, tx_tdata=48'hFFFF_FFFF_FFFF -> spi_ce=2'b01 during the frame, spi_ce[0] never low, 48 sck rising edges.
REQ-035 SHALL pass this case: tx_tvalid held high with two frames, CLKDIV=4 -> second frame accepted in the first rx_tvalid cycle, spi_ce=2'b11 for exactly 4 cycles between frames.
REQ-036 SHALL pass this case: rst pulsed after 10 sck rising edges -> next cycle spi_ce=2'b11, spi_sck=0, tx_tready=1; no rx_tvalid; the following frame is correct.
REQ-037 SHALL pass this case: CLKDIV=1, WIDTH=8, tx_tdata=8'hA5, miso=8'h3C -> sck period 2 clk, rx_tdata=8'h3C at T0+19.
REQ-038 SHALL pass this case: tx_tvalid pulsed mid-frame -> ignored, current frame unaffected, no extra rx_tvalid.
